ram_2d_rd_sched: RTL and testbench

Read-stream scheduler for the banked `ram_2d` buffer. One `cfg_start` request walks a strided sequence of rows across all banks in parallel and drives the shared read port: `re` plus one 32-bit address per bank. It turns the fixed one-cycle RAM read latency into a valid/ready stream with full backpressure support. The stream feeds the butterfly compute lanes and sustains one row per cycle when the consumer never stalls.

---
 rtl/ram_2d_rd_sched.sv | 141 ++++++++++++++
 tb/tb_ram_2d_rd_sched.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_2d_rd_sched.sv
// Read-stream scheduler: walks base + k*stride across all banks and turns the
// one-cycle RAM read latency into a backpressured valid/ready stream.
// Optional build macro RD_SCHED_BANK_SKEW_EN adds the bank index to each bank address.
module ram_2d_rd_sched #(
  parameter int num_rams = 8,
  parameter int w        = 128,
  parameter int d        = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_start,
  input  logic [31:0]            cfg_base,
  input  logic [31:0]            cfg_stride,
  input  logic [15:0]            cfg_len,
  output logic                   busy,
  output logic                   done,
  output logic                   ram_re,
  output logic [num_rams*32-1:0] ram_read_addr,
  input  logic                   ram_dout_vld,
  input  logic [num_rams*w-1:0]  ram_dout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [num_rams*w-1:0]  out_data,
  output logic                   out_last
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [31:0]           addr_q, addr_d;
  logic [31:0]           stride_q, stride_d;
  logic [15:0]           len_q, len_d;
  logic [15:0]           k_q, k_d;
  logic [15:0]           beat_q, beat_d;
  logic                  inflight_q, inflight_d;
  logic [1:0]            cnt_q, cnt_d;
  logic [num_rams*w-1:0] mem0_q, mem0_d;
  logic [num_rams*w-1:0] mem1_q, mem1_d;

  logic       arrive, pop, pop_st, push_st, issue;
  logic [1:0] cnt_after;

  // Stream handshake: a beat transfers on a cycle where out_valid && out_ready;
  // out_valid never drops and out_data never changes until that transfer.
  // Read data arriving this cycle is presented immediately when the skid FIFO is empty.
  assign arrive    = ram_dout_vld & inflight_q;
  assign out_valid = (cnt_q != 2'd0) | arrive;
  assign out_data  = (cnt_q != 2'd0) ? mem0_q : (arrive ? ram_dout : '0);
  assign pop       = out_valid & out_ready;
  assign out_last  = out_valid & (beat_q == (len_q - 16'd1));
  assign pop_st    = pop & (cnt_q != 2'd0);
  assign push_st   = arrive & ~(pop & (cnt_q == 2'd0));

  // Occupancy after this cycle plus the new read must fit in the two skid slots.
  assign issue  = (state_q == S_RUN) && (k_q < len_q) &&
                  (({1'b0, cnt_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  assign ram_re = issue;
  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);

  for (genvar i = 0; i < num_rams; i++) begin : g_lane
`ifdef RD_SCHED_BANK_SKEW_EN
    assign ram_read_addr[32*i +: 32] = issue ? (addr_q + 32'(i)) : 32'd0;
`else
    assign ram_read_addr[32*i +: 32] = issue ? addr_q : 32'd0;
`endif
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    stride_d   = stride_q;
    len_d      = len_q;
    k_d        = k_q;
    beat_d     = pop ? (beat_q + 16'd1) : beat_q;
    inflight_d = issue;
    case (state_q)
      S_IDLE: begin
        if (cfg_start) begin
          addr_d   = cfg_base;
          stride_d = cfg_stride;
          len_d    = cfg_len;
          k_d      = 16'd0;
          beat_d   = 16'd0;
          state_d  = (cfg_len == 16'd0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (issue) begin
          addr_d = addr_q + stride_q;
          k_d    = k_q + 16'd1;
          if ((k_q + 16'd1) == len_q) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (pop && out_last) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    mem0_d    = mem0_q;
    mem1_d    = mem1_q;
    if (pop_st) mem0_d = mem1_q;
    cnt_after = cnt_q - {1'b0, pop_st};
    if (push_st) begin
      if (cnt_after == 2'd0) mem0_d = ram_dout;
      else                   mem1_d = ram_dout;
    end
    cnt_d = cnt_after + {1'b0, push_st};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      stride_q   <= '0;
      len_q      <= '0;
      k_q        <= '0;
      beat_q     <= '0;
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      mem0_q     <= '0;
      mem1_q     <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      stride_q   <= stride_d;
      len_q      <= len_d;
      k_q        <= k_d;
      beat_q     <= beat_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      mem0_q     <= mem0_d;
      mem1_q     <= mem1_d;
    end
  end

endmodule

// File: tb/tb_ram_2d_rd_sched.sv
// Directed bench for ram_2d_rd_sched: a one-cycle RAM model, a row-level
// expectation model (address/data/last queues) and literal timing pins.
module tb_ram_2d_rd_sched;
  localparam int N = 8;
  localparam int W = 128;
`ifdef RD_SCHED_BANK_SKEW_EN
  localparam int SKEW = 1;
`else
  localparam int SKEW = 0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_start;
  logic [31:0]    cfg_base, cfg_stride;
  logic [15:0]    cfg_len;
  logic           busy, done, ram_re;
  logic [N*32-1:0] ram_read_addr;
  logic           ram_dout_vld;
  logic [N*W-1:0] ram_dout = '0;
  logic           out_valid, out_ready, out_last;
  logic [N*W-1:0] out_data;

  ram_2d_rd_sched #(.num_rams(N), .w(W), .d(128)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_base(cfg_base),
    .cfg_stride(cfg_stride), .cfg_len(cfg_len), .busy(busy), .done(done),
    .ram_re(ram_re), .ram_read_addr(ram_read_addr), .ram_dout_vld(ram_dout_vld),
    .ram_dout(ram_dout), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // RAM model: data is a function of lane and address, valid one cycle after re
  function automatic logic [W-1:0] lane_word(input logic [31:0] a, input int i);
    logic [31:0] x;
    x = a ^ 32'h5A5A_0000 ^ (32'(i) << 24);
    return {(W/32){x}};
  endfunction

  logic vld_r = 1'b0;
  logic spur_vld = 1'b0;
  assign ram_dout_vld = vld_r | spur_vld;
  always @(posedge clk) begin
    vld_r <= ram_re;
    for (int i = 0; i < N; i++) ram_dout[i*W +: W] <= lane_word(ram_read_addr[i*32 +: 32], i);
  end

  // scoreboard
  int n_checks = 0;
  int n_fail = 0;
  logic [31:0]    exp_addr_q[$];
  logic [N*W-1:0] exp_q[$];
  bit             exp_last_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N*W-1:0] row_data(input logic [31:0] r);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[i*W +: W] = lane_word(r + 32'(i*SKEW), i);
    return v;
  endfunction

  task automatic model_load(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] len);
    for (int j = 0; j < int'(len); j++) begin
      logic [31:0] r;
      r = base + 32'(j) * stride;
      exp_addr_q.push_back(r);
      exp_q.push_back(row_data(r));
      exp_last_q.push_back(j == int'(len) - 1);
    end
  endtask

  // compare process: every cycle, away from the rising edge
  always @(negedge clk) begin
    if (!rst) begin
      int held;
      held = exp_q.size() - exp_addr_q.size();
      if (ram_re) begin
        chk("rows held <= 2", 64'((held + 1 - int'(out_valid && out_ready)) > 2), 64'd0);
        if (exp_addr_q.size() == 0) chk("unexpected ram_re", 64'd1, 64'd0);
        else begin
          for (int i = 0; i < N; i++)
            chk("ram_read_addr", 64'(ram_read_addr[i*32 +: 32]), 64'(exp_addr_q[0] + 32'(i*SKEW)));
          void'(exp_addr_q.pop_front());
        end
      end
      if (out_valid) begin
        if (exp_q.size() == 0) chk("unexpected out_valid", 64'd1, 64'd0);
        else begin
          n_checks++;
          if (out_data !== exp_q[0]) begin
            n_fail++;
            $display("FAIL out_data: got %h expected %h (low 64 bits) at %0t",
                     out_data[63:0], exp_q[0][63:0], $time);
          end
          chk("out_last", 64'(out_last), 64'(exp_last_q[0]));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(exp_last_q.pop_front());
          end
        end
      end
    end
  end

  // per-cycle record of the latest request, for literal pins
  logic        rec_re[512];
  logic        rec_v[512];
  logic        rec_last[512];
  logic [31:0] rec_a0[512];
  logic [31:0] rec_a3[512];
  logic [31:0] rec_d[512];

  // driver: start a request, drive out_ready, watch busy/done
  task automatic run_stream(input logic [31:0] base, input logic [31:0] stride,
                            input logic [15:0] len, input int rdy_mode,
                            input int start_at, output int done_at);
    bit pat[4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    model_load(base, stride, len);
    @(posedge clk); #1;
    cfg_base = base; cfg_stride = stride; cfg_len = len; cfg_start = 1'b1;
    @(posedge clk); #1;
    cfg_start = 1'b0; cfg_base = 32'hDEAD_0000; cfg_stride = 32'd9; cfg_len = 16'd3;
    done_at = -1;
    for (int n = 1; n < 400; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      cfg_start = (n == start_at);
      out_ready = (rdy_mode == 0) ? 1'b1 : pat[(n-1) % 4];
      @(negedge clk);
      rec_re[n] = ram_re; rec_v[n] = out_valid; rec_last[n] = out_last;
      rec_a0[n] = ram_read_addr[31:0]; rec_a3[n] = ram_read_addr[3*32 +: 32];
      rec_d[n] = out_data[31:0];
      chk("busy during request", 64'(busy), 64'd1);
      if (done) begin done_at = n; break; end
    end
    if (done_at < 0) chk("done timeout", 64'd0, 64'd1);
    @(posedge clk); #1;
    cfg_start = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    chk("busy after done", 64'(busy), 64'd0);
    chk("done single pulse", 64'(done), 64'd0);
    chk("rows outstanding", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int da;
    rst = 1'b1; cfg_start = 1'b0; cfg_base = '0; cfg_stride = '0; cfg_len = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    chk("reset ram_re", 64'(ram_re), 64'd0);
    chk("reset out_valid", 64'(out_valid), 64'd0);
    chk("reset out_last", 64'(out_last), 64'd0);
    chk("reset addr zero", 64'(ram_read_addr == '0), 64'd1);
    chk("reset data zero", 64'(out_data == '0), 64'd1);
    @(posedge clk); #1 rst = 1'b0;

    // basic stream, plus a start held during the DONE cycle
    run_stream(32'd4, 32'd2, 16'd5, 0, 7, da);
    chk("basic done cycle", 64'(da), 64'd7);
    for (int n = 1; n <= 5; n++) chk("basic re", 64'(rec_re[n]), 64'd1);
    chk("basic re stops", 64'(rec_re[6]), 64'd0);
    chk("basic addr0 T+1", 64'(rec_a0[1]), 64'd4);
    chk("basic addr0 T+3", 64'(rec_a0[3]), 64'd8);
    chk("basic addr0 T+5", 64'(rec_a0[5]), 64'd12);
    chk("basic valid T+1", 64'(rec_v[1]), 64'd0);
    chk("basic valid T+2", 64'(rec_v[2]), 64'd1);
    chk("basic data T+2", 64'(rec_d[2]), 64'h5A5A_0004);
    chk("basic last beat3", 64'(rec_last[5]), 64'd0);
    chk("basic last beat4", 64'(rec_last[6]), 64'd1);

    // backpressure with ready 1,0,0,1,... and a start pulse mid-RUN
    run_stream(32'd100, 32'd3, 16'd8, 1, 3, da);

    // zero length
    run_stream(32'd50, 32'd1, 16'd0, 0, 0, da);
    chk("zero done cycle", 64'(da), 64'd1);
    chk("zero no re", 64'(rec_re[1]), 64'd0);
    chk("zero no valid", 64'(rec_v[1]), 64'd0);

    // address wrap, with lane-3 skew when enabled
    run_stream(32'hFFFF_FFFE, 32'd1, 16'd3, 0, 0, da);
    chk("wrap done cycle", 64'(da), 64'd5);
    chk("wrap addr0 0", 64'(rec_a0[1]), 64'hFFFF_FFFE);
    chk("wrap addr0 1", 64'(rec_a0[2]), 64'hFFFF_FFFF);
    chk("wrap addr0 2", 64'(rec_a0[3]), 64'h0000_0000);
`ifdef RD_SCHED_BANK_SKEW_EN
    chk("skew addr3 0", 64'(rec_a3[1]), 64'h0000_0001);
    chk("skew addr3 1", 64'(rec_a3[2]), 64'h0000_0002);
    chk("skew addr3 2", 64'(rec_a3[3]), 64'h0000_0003);
`else
    chk("addr3 0", 64'(rec_a3[1]), 64'hFFFF_FFFE);
    chk("addr3 2", 64'(rec_a3[3]), 64'h0000_0000);
`endif

    // spurious read data while idle must not push
    @(posedge clk); #1 spur_vld = 1'b1;
    @(negedge clk); chk("spurious vld no valid", 64'(out_valid), 64'd0);
    @(posedge clk); #1 spur_vld = 1'b0;
    @(negedge clk); chk("spurious vld not stored", 64'(out_valid), 64'd0);

    // reset mid-stream, with late read data arriving right after release
    model_load(32'd200, 32'd1, 16'd8);
    @(posedge clk); #1;
    cfg_base = 32'd200; cfg_stride = 32'd1; cfg_len = 16'd8; cfg_start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1 cfg_start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mid reset busy", 64'(busy), 64'd0);
    chk("mid reset ram_re", 64'(ram_re), 64'd0);
    chk("mid reset out_valid", 64'(out_valid), 64'd0);
    chk("mid reset out_last", 64'(out_last), 64'd0);
    chk("mid reset addr zero", 64'(ram_read_addr == '0), 64'd1);
    chk("mid reset data zero", 64'(out_data == '0), 64'd1);
    exp_addr_q.delete(); exp_q.delete(); exp_last_q.delete();
    rst = 1'b0;
    @(negedge clk);
    chk("late vld ignored", 64'(out_valid), 64'd0);
    run_stream(32'd7, 32'd3, 16'd4, 0, 0, da);
    chk("post reset done cycle", 64'(da), 64'd6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
